// File: rtl/me_defs_pkg.sv
// Shared definitions for the motion-estimation SAD path: FSM encoding,
// default widths and the SAD saturation constant.
package me_defs_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StDone  = 2'd2
  } me_state_e;

  localparam int unsigned PixelWidthDef   = 8;
  localparam int unsigned MaxDataWidthDef = 16;
  localparam logic [MaxDataWidthDef-1:0] SadMax = {MaxDataWidthDef{1'b1}};

endpackage

// File: rtl/abs_diff.sv
// Combinational unsigned absolute difference |a-b|.
module abs_diff
  import me_defs_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH = PixelWidthDef
) (
  input  logic [PIXEL_WIDTH-1:0] a_i,
  input  logic [PIXEL_WIDTH-1:0] b_i,
  output logic [PIXEL_WIDTH-1:0] diff_o
);

  always_comb begin
    diff_o = (a_i >= b_i) ? (a_i - b_i) : (b_i - a_i);
  end

endmodule

// File: rtl/sad_stream_generator.sv
// Accumulates saturating |cur-ref| over BLOCK_PIXELS pairs per candidate and
// emits one SAD pulse per candidate for NUM_CANDIDATES candidates per search.
module sad_stream_generator
  import me_defs_pkg::*;
#(
  parameter int unsigned MAX_DATA_WIDTH = MaxDataWidthDef,
  parameter int unsigned PIXEL_WIDTH    = PixelWidthDef,
  parameter int unsigned BLOCK_PIXELS   = 16,
  parameter int unsigned NUM_CANDIDATES = 16,
  parameter int unsigned COUNTER_WIDTH  = 9
) (
  input  logic                      in_clk,
  input  logic                      in_rst,
  input  logic                      in_start,
  input  logic [PIXEL_WIDTH-1:0]    in_cur_pixel,
  input  logic [PIXEL_WIDTH-1:0]    in_ref_pixel,
  input  logic                      in_pixel_valid,
  output logic                      out_pixel_ready,
  output logic [MAX_DATA_WIDTH-1:0] out_SAD,
  output logic                      out_SAD_valid,
  output logic [COUNTER_WIDTH-1:0]  out_candidate_idx,
  output logic                      out_busy,
  output logic                      out_done
);

  localparam int unsigned PixCntW = $clog2(BLOCK_PIXELS);
  localparam int unsigned SumW    = MAX_DATA_WIDTH + 1;
  localparam logic [PixCntW-1:0]        LastPix  = PixCntW'(BLOCK_PIXELS - 1);
  localparam logic [COUNTER_WIDTH-1:0]  LastCand = COUNTER_WIDTH'(NUM_CANDIDATES - 1);
  localparam logic [MAX_DATA_WIDTH-1:0] SadMaxW  = {MAX_DATA_WIDTH{1'b1}};

  me_state_e                 state_q, state_d;
  logic [MAX_DATA_WIDTH-1:0] acc_q, acc_d, sad_q, sad_d;
  logic [PixCntW-1:0]        pix_cnt_q, pix_cnt_d;
  logic [COUNTER_WIDTH-1:0]  cand_cnt_q, cand_cnt_d, idx_q, idx_d;
  logic                      sad_valid_q, sad_valid_d, done_q, done_d;

  logic [PIXEL_WIDTH-1:0]    diff;
  logic [SumW-1:0]           sum;
  logic [MAX_DATA_WIDTH-1:0] acc_sat;
  logic                      xfer, last_pix;

  abs_diff #(
    .PIXEL_WIDTH(PIXEL_WIDTH)
  ) u_abs_diff (
    .a_i   (in_cur_pixel),
    .b_i   (in_ref_pixel),
    .diff_o(diff)
  );

  // One spare bit catches the carry so the sum clamps instead of wrapping.
  always_comb begin
    sum      = {1'b0, acc_q} + SumW'(diff);
    acc_sat  = sum[MAX_DATA_WIDTH] ? SadMaxW : sum[MAX_DATA_WIDTH-1:0];
    xfer     = in_pixel_valid && (state_q == StAccum);
    last_pix = (pix_cnt_q == LastPix);
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      pix_cnt_q   <= '0;
      cand_cnt_q  <= '0;
      sad_q       <= '0;
      idx_q       <= '0;
      sad_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      pix_cnt_q   <= pix_cnt_d;
      cand_cnt_q  <= cand_cnt_d;
      sad_q       <= sad_d;
      idx_q       <= idx_d;
      sad_valid_q <= sad_valid_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_start) state_d = StAccum;
      StAccum: if (xfer && last_pix && (cand_cnt_q == LastCand)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    acc_d       = acc_q;
    pix_cnt_d   = pix_cnt_q;
    cand_cnt_d  = cand_cnt_q;
    sad_d       = sad_q;
    idx_d       = idx_q;
    sad_valid_d = 1'b0;
    // Registered one cycle after the final SAD pulse, i.e. while leaving DONE.
    done_d      = (state_q == StDone);
    if ((state_q == StIdle) && in_start) begin
      acc_d      = '0;
      pix_cnt_d  = '0;
      cand_cnt_d = '0;
    end else if (xfer) begin
      if (last_pix) begin
        sad_d       = acc_sat;
        sad_valid_d = 1'b1;
        idx_d       = cand_cnt_q;
        acc_d       = '0;
        pix_cnt_d   = '0;
        cand_cnt_d  = cand_cnt_q + COUNTER_WIDTH'(1);
      end else begin
        acc_d     = acc_sat;
        pix_cnt_d = pix_cnt_q + PixCntW'(1);
      end
    end
  end

  always_comb begin
    out_pixel_ready   = (state_q == StAccum);
    out_busy          = (state_q != StIdle);
    out_SAD           = sad_q;
    out_SAD_valid     = sad_valid_q;
    out_candidate_idx = idx_q;
    out_done          = done_q;
  end

endmodule

// File: doc/sad_stream_generator.md
Name: sad_stream_generator

Overview:
- Producer side of the SAD min-tracking interface. Streams one sum-of-absolute-differences value with a one-cycle valid pulse per search candidate into the minimum tracker.
- Consumes current/reference pixel pairs through a valid/ready handshake and accumulates |cur-ref| over BLOCK_PIXELS pairs per candidate.
- Sequences NUM_CANDIDATES candidates per search, then signals completion.

Parameters:
- MAX_DATA_WIDTH, 16, width of emitted SAD; accumulator saturates at 2^MAX_DATA_WIDTH-1
- PIXEL_WIDTH, 8, width of each pixel sample
- BLOCK_PIXELS, 16, pixel pairs per candidate block (>=2)
- NUM_CANDIDATES, 16, candidates per search (>=1)
- COUNTER_WIDTH, 9, width of candidate counter/index; must hold NUM_CANDIDATES

Ports:
- in_clk  input  1  clock, all state on rising edge
- in_rst  input  1  asynchronous, active-high reset
- in_start  input  1  begin a search; sampled only in IDLE
- in_cur_pixel  input  PIXEL_WIDTH  current-frame pixel
- in_ref_pixel  input  PIXEL_WIDTH  reference-frame pixel
- in_pixel_valid  input  1  pixel pair valid
- out_pixel_ready  output  1  block accepts pixel pair this cycle
- out_SAD  output  MAX_DATA_WIDTH  completed candidate SAD
- out_SAD_valid  output  1  one-cycle pulse, out_SAD/out_candidate_idx valid
- out_candidate_idx  output  COUNTER_WIDTH  index of the emitted candidate, 0..NUM_CANDIDATES-1
- out_busy  output  1  search in progress
- out_done  output  1  one-cycle pulse, search complete

Behaviour:
- Reset is asynchronous and active-high. All outputs are 0, the FSM is IDLE, and the accumulator and counters are 0. Reset mid-search abandons the search with no SAD or done pulse.
- FSM states are IDLE, ACCUM and DONE.
- IDLE:
  - out_pixel_ready=0, out_busy=0.
  - in_start=1 moves the FSM to ACCUM and clears the accumulator, pixel counter and candidate counter.
- ACCUM:
  - out_pixel_ready=1, out_busy=1. in_start is ignored.
  - A transfer occurs on any edge with in_pixel_valid && out_pixel_ready. Each transfer does acc <= sat(acc + |cur-ref|) and increments the pixel counter.
  - On the transfer where pixel counter == BLOCK_PIXELS-1:
    - out_SAD <= sat(acc + |cur-ref|), out_SAD_valid <= 1, out_candidate_idx <= candidate counter.
    - acc and pixel counter clear; candidate counter increments.
  - Latency is 1 cycle: the SAD is visible the cycle after the last pixel is accepted.
  - There is no bubble between candidates. The next candidate's first pixel can be accepted on the edge where out_SAD_valid rises.
  - Last pixel of candidate NUM_CANDIDATES-1 moves the FSM to DONE.
- DONE:
  - out_pixel_ready=0, out_busy=1 for one cycle.
  - out_done is registered high the cycle after the final out_SAD_valid pulse, then the FSM returns to IDLE.
  - in_start in DONE is ignored.
- Pixel valid outside ACCUM is ignored and does not affect state.
- Arithmetic:
  - |cur-ref| is computed as unsigned PIXEL_WIDTH.
  - The sum uses a MAX_DATA_WIDTH+1 intermediate and clamps to all-ones on overflow. Wrap-around is forbidden.
- out_SAD holds its last value between pulses. out_SAD_valid is high for exactly one cycle per candidate.
- Exactly NUM_CANDIDATES SAD pulses occur per search, which matches the tracker's count-to-16 termination.

Decomposition:
- Shared package/include me_defs holds:
  - FSM state encodings (IDLE=0, ACCUM=1, DONE=2)
  - the PIXEL_WIDTH default
  - the saturation constant SAD_MAX = {MAX_DATA_WIDTH{1'b1}}
- One natural sub-module: abs_diff, a combinational |a-b| over PIXEL_WIDTH, instantiated once.

Test Plan:
- Reset, then start, with 16×16 pairs (cur=10, ref=7), valid always high. Required response:
  - 16 SAD pulses, each out_SAD=48, idx 0..15 consecutive
  - pulses spaced 16 cycles apart
  - out_done one cycle after the 16th pulse, then busy=0
- Candidate k uses cur=k, ref=0 with the valid gapped every other cycle. Required response: out_SAD=16k per candidate, and no pixel is counted on cycles where valid is low.
- MAX_DATA_WIDTH=8 with pairs cur=255, ref=0. Required response: out_SAD saturates at 255 and does not wrap to 240.
- in_start pulsed mid-ACCUM and in DONE. Required response: ignored, counts unchanged.
- Assert in_rst after 5 candidates. Required response:
  - all outputs go to 0 immediately
  - no out_done pulse
  - a fresh start then gives idx restarting at 0
- Connect to the min tracker with candidate SADs descending, 100 down to 85. Required response: the tracker's final min is 85 and its DONE asserts after the generator's out_done.
